// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - groups COUNT multiplier products into sums behind a 2-entry output FIFO
// Optional ACC_SATURATE_EN: clamp the accumulator on carry-out instead of wrapping.
module product_accumulator #(
  parameter int PWIDTH  = 128,
  parameter int ACCW    = 136,
  parameter int LATENCY = 2,
  parameter int COUNT   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [PWIDTH-1:0] y,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACCW-1:0]   sum,
  output logic              overrun,
  output logic              overflow
);

  localparam int CW = $clog2(COUNT + 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t             state;
  logic [LATENCY-1:0] vld_sr;
  logic               pvalid;
  logic [ACCW-1:0]    acc;
  logic [CW-1:0]      cnt;
  logic [ACCW-1:0]    ext_y;
  logic [ACCW:0]      add;
  logic               carry;
  logic [ACCW-1:0]    acc_next;
  logic               push;
  logic [ACCW-1:0]    push_data;

  logic [ACCW-1:0]    mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         fcnt;
  logic               pop;
  logic               wr_en;

  assign pvalid = vld_sr[LATENCY-1];
  assign ext_y  = ACCW'(y);
  assign add    = {1'b0, acc} + {1'b0, ext_y};
  assign carry  = add[ACCW];

`ifdef ACC_SATURATE_EN
  assign acc_next = carry ? {ACCW{1'b1}} : add[ACCW-1:0];
`else
  assign acc_next = add[ACCW-1:0];
`endif

  // Decide whether this cycle closes a group and what value the group carries.
  always_comb begin
    push      = 1'b0;
    push_data = acc;
    if (state == IDLE) begin
      if (pvalid && (COUNT == 1 || flush)) begin
        push      = 1'b1;
        push_data = ext_y;
      end
    end else begin
      if (pvalid) begin
        if ((cnt + CW'(1) == CW'(COUNT)) || flush) begin
          push      = 1'b1;
          push_data = acc_next;
        end
      end else if (flush) begin
        push      = 1'b1;
        push_data = acc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= in_valid;
      for (int i = 1; i < LATENCY; i++) vld_sr[i] <= vld_sr[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pvalid && !push) begin
            acc   <= ext_y;
            cnt   <= CW'(1);
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (pvalid) begin
            if (carry) overflow <= 1'b1;
            if (push) begin
              state <= IDLE;
            end else begin
              acc <= acc_next;
              cnt <= cnt + CW'(1);
            end
          end else if (flush) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (fcnt != 2'd0);
  assign sum       = mem[rd_ptr];
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign wr_en     = push && ((fcnt != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      fcnt    <= 2'd0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !wr_en) overrun <= 1'b1;
      case ({wr_en, pop})
        2'b10:   fcnt <= fcnt + 2'd1;
        2'b01:   fcnt <= fcnt - 2'd1;
        default: fcnt <= fcnt;
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator
module tb_product_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       en2;
  logic [7:0] yin;
  logic [7:0] ypipe [2];
  logic [7:0] y;
  logic       flush;
  logic       out_ready;
  logic       out_ready2;
  logic       out_valid, out_valid2;
  logic [9:0] sum;
  logic [8:0] sum2;
  logic       overrun, overrun2, overflow, overflow2;

  int tests = 0;
  int fails = 0;
  int exp_q1 [$];
  int exp_q2 [$];

  always #5 clk = ~clk;

  // Behavioural two-stage multiplier: the product follows in_valid by LATENCY edges.
  always @(posedge clk) begin
    ypipe[0] <= yin;
    ypipe[1] <= ypipe[0];
  end
  assign y = ypipe[1];

  product_accumulator #(.PWIDTH(8), .ACCW(10), .LATENCY(2), .COUNT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .y(y), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .overrun(overrun), .overflow(overflow)
  );

  product_accumulator #(.PWIDTH(8), .ACCW(9), .LATENCY(2), .COUNT(4)) dut9 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & en2), .y(y), .flush(1'b0),
    .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
    .overrun(overrun2), .overflow(overflow2)
  );

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q1.size() == 0) check("unexpected_sum", int'(sum), -1);
      else check("sum", int'(sum), exp_q1.pop_front());
    end
    if (rst_n && out_valid2 && out_ready2) begin
      if (exp_q2.size() == 0) check("unexpected_sum9", int'(sum2), -1);
      else check("sum9", int'(sum2), exp_q2.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  task automatic issue(input int v);
    cyc();
    in_valid = 1'b1;
    yin      = 8'(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; en2 = 1'b0; yin = '0; flush = 1'b0;
    out_ready = 1'b1; out_ready2 = 1'b1;
    #12;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_overflow", int'(overflow), 0);
    cyc();
    rst_n = 1'b1;
    idle(2);

    // Basic group of four, with latency check
    exp_q1.push_back(100);
    for (int i = 0; i < 4; i++) issue(10 * (i + 1));
    idle(1);
    cyc();
    @(negedge clk);
    check("latency_early", int'(out_valid), 0);
    cyc();
    @(negedge clk);
    check("latency_on_time", int'(out_valid), 1);
    idle(4);

    // Early flush after two products, then a flush in IDLE
    exp_q1.push_back(12);
    issue(5);
    issue(7);
    idle(2);
    cyc();
    flush = 1'b1;
    idle(5);
    cyc();
    flush = 1'b1;
    idle(5);
    check("idle_flush_no_output", int'(out_valid), 0);

    // 255 products: no overflow at ACCW=10, carry-out at ACCW=9
    exp_q1.push_back(1020);
    exp_q1.push_back(1020);
`ifdef ACC_SATURATE_EN
    exp_q2.push_back(511);
    exp_q2.push_back(511);
`else
    exp_q2.push_back(508);
    exp_q2.push_back(508);
`endif
    en2 = 1'b1;
    for (int i = 0; i < 8; i++) issue(255);
    idle(6);
    en2 = 1'b0;
    check("overflow_w10", int'(overflow), 0);
    check("overflow_w9", int'(overflow2), 1);

    // Stalled consumer: two groups held, third dropped
    out_ready = 1'b0;
    exp_q1.push_back(10);
    exp_q1.push_back(26);
    for (int i = 1; i <= 12; i++) issue(i);
    idle(6);
    @(negedge clk);
    check("overrun_set", int'(overrun), 1);
    check("held_valid", int'(out_valid), 1);
    check("held_sum", int'(sum), 10);
    cyc();
    out_ready = 1'b1;
    idle(3);
    check("drained_valid", int'(out_valid), 0);

    // Reset in the middle of a group
    issue(9);
    issue(9);
    cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_sum", int'(sum), 0);
    check("midrst_overrun", int'(overrun), 0);
    check("midrst_overflow", int'(overflow), 0);
    cyc();
    rst_n = 1'b1;
    idle(3);
    check("after_rst_quiet", int'(out_valid), 0);
    exp_q1.push_back(4);
    for (int i = 0; i < 4; i++) issue(1);
    idle(8);

    // Third push coincides with the only pop on a full FIFO
    out_ready = 1'b0;
    exp_q1.push_back(4);
    exp_q1.push_back(8);
    exp_q1.push_back(12);
    for (int g = 1; g <= 3; g++)
      for (int i = 0; i < 4; i++) issue(g);
    cyc();
    in_valid = 1'b0;
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    idle(2);
    @(negedge clk);
    check("pushpop_no_overrun", int'(overrun), 0);
    check("pushpop_valid", int'(out_valid), 1);
    cyc();
    out_ready = 1'b1;
    idle(4);
    check("final_empty", int'(out_valid), 0);

    check("queue1_drained", exp_q1.size(), 0);
    check("queue2_drained", exp_q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
